filter_read_sequencer: RTL and testbench

Walks the filter scratchpad for the convolution datapath. For each filter it issues one read address per filter element, `num_passes` times over, through a valid/ready handshake to the PE read port. After each completed filter it emits the one-cycle `next_filter` pulse that advances the filter start-address tracker, then resumes from the tracker's updated `filter_start_addr`. It is the producer of `next_filter` and the consumer of the start address the tracker maintains.

---
 rtl/filter_read_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_filter_read_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_read_sequencer.sv
// -----------------------------------------------------------------------------
// filter_read_sequencer
//
// Walks the filter scratchpad for the convolution datapath. For every filter
// it issues filter_size read addresses, num_passes times over, to the PE read
// port through a valid/ready handshake. When a filter is complete it pulses
// next_filter_o so the start-address tracker advances. It then waits one
// settle cycle and resumes from the tracker's updated filter_start_addr_i.
//
// Ports
//   clk_i               clock, rising edge
//   rst_i               asynchronous active-high reset
//   start_i             begin a run (honoured only while idle)
//   filter_size_i       elements per filter, latched on accepted start
//   num_passes_i        reads of each filter, latched on accepted start
//   num_filters_i       filters per run, latched on accepted start
//   filter_start_addr_i start address of the current filter (from tracker)
//   rd_addr_o           filter_start_addr_i + element index (wraps)
//   rd_valid_o          rd_addr_o is valid
//   rd_ready_i          consumer accepts rd_addr_o
//   rd_last_o           last element of a pass (qualified by rd_valid_o)
//   next_filter_o       one-cycle pulse after each completed filter
//   busy_o              high whenever the sequencer is not idle
//   done_o              one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module filter_read_sequencer #(
    parameter int ADDR_WIDTH      = 16,
    parameter int MAX_FILTER_SIZE = 4,
    parameter int PASS_WIDTH      = 8,
    parameter int FILT_WIDTH      = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [MAX_FILTER_SIZE-1:0] filter_size_i,
    input  logic [PASS_WIDTH-1:0]      num_passes_i,
    input  logic [FILT_WIDTH-1:0]      num_filters_i,
    input  logic [ADDR_WIDTH-1:0]      filter_start_addr_i,
    output logic [ADDR_WIDTH-1:0]      rd_addr_o,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic                       rd_last_o,
    output logic                       next_filter_o,
    output logic                       busy_o,
    output logic                       done_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_ADVANCE = 3'd2,
        S_SETTLE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                     state_q;
    logic [MAX_FILTER_SIZE-1:0] size_q;
    logic [PASS_WIDTH-1:0]      passes_q;
    logic [FILT_WIDTH-1:0]      filters_q;
    logic [MAX_FILTER_SIZE-1:0] elem_cnt_q;
    logic [PASS_WIDTH-1:0]      pass_cnt_q;
    logic [FILT_WIDTH-1:0]      filt_cnt_q;
    logic                       rd_valid_q;
    logic                       rd_last_q;
    logic                       next_filter_q;
    logic                       busy_q;
    logic                       done_q;

    logic                       hs_s;
    logic                       elem_last_s;
    logic                       elem_next_last_s;
    logic                       pass_last_s;
    logic                       filt_last_s;
    logic                       any_zero_s;

    // Handshake and counter terminal-count decodes.
    always_comb begin
        hs_s             = rd_valid_q & rd_ready_i;
        elem_last_s      = (elem_cnt_q == (size_q - {{(MAX_FILTER_SIZE-1){1'b0}}, 1'b1}));
        // True when the element after the current one closes the pass; this
        // lets rd_last be registered alongside the advanced address.
        elem_next_last_s = ((elem_cnt_q + {{(MAX_FILTER_SIZE-1){1'b0}}, 1'b1})
                            == (size_q - {{(MAX_FILTER_SIZE-1){1'b0}}, 1'b1}));
        pass_last_s      = (pass_cnt_q == (passes_q - {{(PASS_WIDTH-1){1'b0}}, 1'b1}));
        filt_last_s      = (filt_cnt_q == (filters_q - {{(FILT_WIDTH-1){1'b0}}, 1'b1}));
        any_zero_s       = (filter_size_i == {MAX_FILTER_SIZE{1'b0}})
                         | (num_passes_i  == {PASS_WIDTH{1'b0}})
                         | (num_filters_i == {FILT_WIDTH{1'b0}});
    end

    // Address is combinational on the tracker input so a tracker update in
    // SETTLE is picked up without an extra register stage.
    assign rd_addr_o     = filter_start_addr_i + ADDR_WIDTH'(elem_cnt_q);
    assign rd_valid_o    = rd_valid_q;
    assign rd_last_o     = rd_last_q;
    assign next_filter_o = next_filter_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

    // Sequencer FSM: state, counters, latched run parameters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            size_q        <= {MAX_FILTER_SIZE{1'b0}};
            passes_q      <= {PASS_WIDTH{1'b0}};
            filters_q     <= {FILT_WIDTH{1'b0}};
            elem_cnt_q    <= {MAX_FILTER_SIZE{1'b0}};
            pass_cnt_q    <= {PASS_WIDTH{1'b0}};
            filt_cnt_q    <= {FILT_WIDTH{1'b0}};
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
            next_filter_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        size_q     <= filter_size_i;
                        passes_q   <= num_passes_i;
                        filters_q  <= num_filters_i;
                        elem_cnt_q <= {MAX_FILTER_SIZE{1'b0}};
                        pass_cnt_q <= {PASS_WIDTH{1'b0}};
                        filt_cnt_q <= {FILT_WIDTH{1'b0}};
                        busy_q     <= 1'b1;
                        if (any_zero_s) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_READ;
                            rd_valid_q <= 1'b1;
                            rd_last_q  <= (filter_size_i == {{(MAX_FILTER_SIZE-1){1'b0}}, 1'b1});
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (hs_s) begin
                        if (elem_last_s) begin
                            elem_cnt_q <= {MAX_FILTER_SIZE{1'b0}};
                            if (pass_last_s) begin
                                pass_cnt_q    <= {PASS_WIDTH{1'b0}};
                                state_q       <= S_ADVANCE;
                                rd_valid_q    <= 1'b0;
                                rd_last_q     <= 1'b0;
                                next_filter_q <= 1'b1;
                            end else begin
                                // Next pass starts immediately: no bubble.
                                pass_cnt_q <= pass_cnt_q + {{(PASS_WIDTH-1){1'b0}}, 1'b1};
                                rd_last_q  <= (size_q == {{(MAX_FILTER_SIZE-1){1'b0}}, 1'b1});
                            end
                        end else begin
                            elem_cnt_q <= elem_cnt_q + {{(MAX_FILTER_SIZE-1){1'b0}}, 1'b1};
                            rd_last_q  <= elem_next_last_s;
                        end
                    end else begin
                        state_q <= S_READ;
                    end
                end
                S_ADVANCE: begin
                    next_filter_q <= 1'b0;
                    if (filt_last_s) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        filt_cnt_q <= filt_cnt_q + {{(FILT_WIDTH-1){1'b0}}, 1'b1};
                        state_q    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    state_q    <= S_READ;
                    rd_valid_q <= 1'b1;
                    rd_last_q  <= (size_q == {{(MAX_FILTER_SIZE-1){1'b0}}, 1'b1});
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q       <= S_IDLE;
                    rd_valid_q    <= 1'b0;
                    rd_last_q     <= 1'b0;
                    next_filter_q <= 1'b0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_read_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for filter_read_sequencer. Inputs change #1
// after each rising edge; outputs are checked at that same point, i.e. they
// reflect the state entered on the preceding edge ("cycle k" = after edge k-1).
// -----------------------------------------------------------------------------
module tb_filter_read_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  filter_size_i;
    logic [7:0]  num_passes_i;
    logic [7:0]  num_filters_i;
    logic [15:0] filter_start_addr_i;
    logic [15:0] rd_addr_o;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic        rd_last_o;
    logic        next_filter_o;
    logic        busy_o;
    logic        done_o;

    int compared   = 0;
    int mismatched = 0;
    int hs_count;

    filter_read_sequencer #(
        .ADDR_WIDTH(16), .MAX_FILTER_SIZE(4), .PASS_WIDTH(8), .FILT_WIDTH(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .filter_size_i(filter_size_i), .num_passes_i(num_passes_i),
        .num_filters_i(num_filters_i), .filter_start_addr_i(filter_start_addr_i),
        .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_last_o(rd_last_o), .next_filter_o(next_filter_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Compare all outputs at once: {valid,last,next_filter,busy,done,addr}.
    task automatic exp_out(input string tag, input logic v, input logic l,
                           input logic n, input logic b, input logic d,
                           input logic [15:0] a);
        logic [20:0] obs;
        logic [20:0] exp;
        obs = {rd_valid_o, rd_last_o, next_filter_o, busy_o, done_o, rd_addr_o};
        exp = {v, l, n, b, d, a};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed v%b l%b n%b b%b d%b a%h expected v%b l%b n%b b%b d%b a%h",
                   tag, obs[20], obs[19], obs[18], obs[17], obs[16], obs[15:0],
                   v, l, n, b, d, a);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [3:0] sz, input logic [7:0] ps, input logic [7:0] fl);
        filter_size_i = sz;
        num_passes_i  = ps;
        num_filters_i = fl;
        start_i       = 1'b1;
        tick();
        start_i       = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; rd_ready_i = 1'b1;
        filter_size_i = 4'd0; num_passes_i = 8'd0; num_filters_i = 8'd0;
        filter_start_addr_i = 16'h0010;
        #3;
        exp_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);
        rst_i = 1'b0;
        tick();
        exp_out("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);

        // size=3, passes=1, filters=1 at 0x0010
        launch(4'd3, 8'd1, 8'd1);
        exp_out("t1_c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010); tick();
        exp_out("t1_c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0011); tick();
        exp_out("t1_c3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0012); tick();
        exp_out("t1_nf", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010); tick();
        exp_out("t1_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010); tick();
        exp_out("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);

        // size=2, passes=3: 0,1,0,1,0,1 with no bubbles
        filter_start_addr_i = 16'h0000;
        launch(4'd2, 8'd3, 8'd1);
        for (int i = 0; i < 6; i++) begin
            exp_out($sformatf("t2_c%0d", i + 1), 1'b1, (i % 2) == 1, 1'b0, 1'b1, 1'b0,
                    16'(i % 2));
            tick();
        end
        exp_out("t2_nf", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); tick();
        exp_out("t2_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000); tick();
        exp_out("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // size=4, passes=1, filters=2; tracker adds 4 per next_filter
        filter_start_addr_i = 16'h0000;
        launch(4'd4, 8'd1, 8'd2);
        for (int i = 0; i < 4; i++) begin
            exp_out($sformatf("t3_f0_%0d", i), 1'b1, i == 3, 1'b0, 1'b1, 1'b0, 16'(i));
            tick();
        end
        exp_out("t3_nf0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        filter_start_addr_i = filter_start_addr_i + 16'd4;
        tick();
        exp_out("t3_settle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004); tick();
        for (int i = 0; i < 4; i++) begin
            exp_out($sformatf("t3_f1_%0d", i), 1'b1, i == 3, 1'b0, 1'b1, 1'b0, 16'(4 + i));
            tick();
        end
        exp_out("t3_nf1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0004);
        filter_start_addr_i = filter_start_addr_i + 16'd4;
        tick();
        exp_out("t3_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0008); tick();
        exp_out("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0008);

        // Stall: rd_ready 1,0,0,1 then held high, size=4 at 0x0020
        filter_start_addr_i = 16'h0020;
        hs_count = 0;
        launch(4'd4, 8'd1, 8'd1);
        rd_ready_i = 1'b1;
        exp_out("t4_c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020);
        if (rd_valid_o && rd_ready_i) hs_count++;
        tick();
        rd_ready_i = 1'b0;
        exp_out("t4_c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0021);
        if (rd_valid_o && rd_ready_i) hs_count++;
        tick();
        exp_out("t4_c3_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0021);
        if (rd_valid_o && rd_ready_i) hs_count++;
        tick();
        rd_ready_i = 1'b1;
        exp_out("t4_c4_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0021);
        if (rd_valid_o && rd_ready_i) hs_count++;
        tick();
        exp_out("t4_c5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0022);
        if (rd_valid_o && rd_ready_i) hs_count++;
        tick();
        exp_out("t4_c6", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0023);
        if (rd_valid_o && rd_ready_i) hs_count++;
        tick();
        exp_out("t4_nf", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020);
        if (rd_valid_o && rd_ready_i) hs_count++;
        tick();
        chk_int("t4_handshakes", hs_count, 4);
        exp_out("t4_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020); tick();

        // filters=0: done one cycle after start, no reads
        launch(4'd3, 8'd1, 8'd0);
        exp_out("t5_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020); tick();
        exp_out("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020);
        // passes=0 behaves the same way
        launch(4'd2, 8'd0, 8'd3);
        exp_out("t5b_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020); tick();
        exp_out("t5b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020);

        // Reset mid-READ in the second filter with elem_cnt=2
        filter_start_addr_i = 16'h0000;
        launch(4'd4, 8'd1, 8'd2);
        repeat (4) tick();
        exp_out("t6_nf0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        filter_start_addr_i = filter_start_addr_i + 16'd4;
        tick();
        tick();
        exp_out("t6_f1_e0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0004); tick();
        tick();
        exp_out("t6_f1_e2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0006);
        rst_i = 1'b1;
        #1;
        exp_out("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004);
        filter_start_addr_i = 16'h0040;
        rst_i = 1'b0;
        tick();
        exp_out("t6_post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040);

        // Fresh run from zeroed counters; start during busy is ignored
        launch(4'd2, 8'd1, 8'd1);
        exp_out("t7_c1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040);
        start_i = 1'b1;
        filter_size_i = 4'd3;
        num_filters_i = 8'd5;
        tick();
        exp_out("t7_c2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0041);
        tick();
        start_i = 1'b0;
        exp_out("t7_nf", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040); tick();
        exp_out("t7_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040); tick();
        exp_out("t7_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
